puf_response_collector: RTL and testbench
=========================================

Name: puf_response_collector

Overview:
- Sequences a challenge sweep through the RO race stage and collects one response bit per challenge.
- For each challenge it drives the challenge, then holds the race counters and arbiter in reset. It then releases them and waits for the arbiter done.
- It captures the arbiter out bit and packs RESP_BITS results into a response word.
- Sits directly downstream of race_arbiter (consumes out/done, drives its reset) and upstream of the host/UART readout.

Parameters:
RESP_BITS, 32, number of challenges per sweep / response width (2..64)
CHAL_BITS, 8, challenge width driven to RO mux selects
SETTLE_CYCLES, 4, cycles arb_reset is held high before each race (>=1)
TIMEOUT_CYCLES, 65535, max cycles waiting for arbiter done per bit (>=4)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins sweep when idle
challenge_base  input  CHAL_BITS  first challenge of sweep, sampled on accepted start
arb_done  input  1  race_arbiter done (asynchronous to clk)
arb_out  input  1  race_arbiter out (asynchronous to clk)
arb_reset  output  1  active-high reset to race counters and race_arbiter
challenge_out  output  CHAL_BITS  current challenge to RO muxes
busy  output  1  high from accepted start until valid pulse
bit_index  output  $clog2(RESP_BITS)  index of bit currently being raced
response  output  RESP_BITS  collected response
valid  output  1  one-cycle pulse when response complete
timeout_err  output  1  sticky: at least one bit of last sweep timed out

Behaviour:
- Reset (reset_n low, async), required output values:
  - arb_reset=1; busy=0; valid=0; timeout_err=0; response=0; bit_index=0; challenge_out=0.
  - FSM goes to IDLE; synchronisers are cleared.
- Synchronisation: arb_done and arb_out each pass through a 2-flop synchroniser. All decisions use the synchronised versions (done_s, out_s).
- FSM states: IDLE, CLEAR, RACE, CAPTURE, NEXT, FINISH.
- IDLE:
  - arb_reset=1.
  - start=1 latches challenge_base into challenge_out, clears response/timeout_err/bit_index, sets busy, and goes to CLEAR next cycle.
  - start while busy is ignored.
- CLEAR:
  - arb_reset=1 for exactly SETTLE_CYCLES cycles (settle counter), then go to RACE.
  - challenge_out is stable throughout.
- RACE:
  - arb_reset=0; a timeout counter counts from 0.
  - done_s=1 -> CAPTURE.
  - Counter reaches TIMEOUT_CYCLES-1 without done_s -> CAPTURE with forced bit 0 and timeout_err set.
  - done_s already high on the first RACE cycle (stale) is still accepted. Clearing it is CLEAR's responsibility; SETTLE_CYCLES>=3 covers the synchroniser latency, and 4 is the default.
- CAPTURE (1 cycle): response[bit_index] <= out_s (or 0 on timeout); arb_reset=1.
- NEXT (1 cycle):
  - bit_index==RESP_BITS-1 -> FINISH.
  - Otherwise bit_index+1, challenge_out+1 (wraps modulo 2^CHAL_BITS, e.g. 0xFF->0x00), then CLEAR.
- FINISH (1 cycle): valid=1, busy=0, then IDLE.
- Holding behaviour:
  - response and timeout_err hold until the next accepted start.
  - challenge_out holds its last value in IDLE.
- Bit order: response[i] corresponds to challenge challenge_base+i.
- Per-bit latency: SETTLE_CYCLES + race time + 2 (sync) + 2 (CAPTURE/NEXT).
- arb_reset is high in every state except RACE.
- Reset mid-sweep: abort immediately to reset values. No valid pulse; a partial response is discarded.
- start coincident with FINISH is ignored (busy still high that cycle).

Test Plan:
- RESP_BITS=4, base=0x10; model arbiter asserts done 20 cycles after arb_reset falls, out pattern 1,0,1,1 -> response=4'b1101, challenge_out sequence 0x10..0x13, single valid pulse, timeout_err=0.
- base=0xFE, RESP_BITS=4 -> challenge_out sequence 0xFE,0xFF,0x00,0x01.
- TIMEOUT_CYCLES=16, done never asserted for bit 2 (others out=1) -> response=4'b1011, timeout_err=1, sweep completes.
- Check arb_reset high for exactly SETTLE_CYCLES=4 cycles before each race and low only during RACE; start pulses during busy -> no restart, one valid.
- Assert reset_n low mid-RACE of bit 1 -> outputs immediately at reset values, arb_reset=1, no valid. A new start afterwards yields a correct full sweep.
- arb_done/arb_out toggled asynchronously (random phase vs clk) -> captured bit equals arbiter out, no X propagation.

Source files
------------

// File: rtl/puf_response_collector_if.sv
// Interface bundling the collector's host-side and arbiter-side signals.
//   master : the collector (drives arb_reset, challenge_out, busy, bit_index,
//            response, valid, timeout_err; receives start, challenge_base,
//            arb_done, arb_out)
//   slave  : the environment (host plus race_arbiter), opposite directions
interface puf_response_collector_if #(
  parameter int unsigned RESP_BITS = 32,
  parameter int unsigned CHAL_BITS = 8
);
  localparam int unsigned IdxW = $clog2(RESP_BITS);

  logic                 start;
  logic [CHAL_BITS-1:0] challenge_base;
  logic                 arb_done;
  logic                 arb_out;
  logic                 arb_reset;
  logic [CHAL_BITS-1:0] challenge_out;
  logic                 busy;
  logic [IdxW-1:0]      bit_index;
  logic [RESP_BITS-1:0] response;
  logic                 valid;
  logic                 timeout_err;

  modport master (
    input  start, challenge_base, arb_done, arb_out,
    output arb_reset, challenge_out, busy, bit_index, response, valid, timeout_err
  );

  modport slave (
    output start, challenge_base, arb_done, arb_out,
    input  arb_reset, challenge_out, busy, bit_index, response, valid, timeout_err
  );
endinterface

// File: rtl/puf_response_collector.sv
// Sweeps RESP_BITS consecutive challenges through the RO race stage and packs
// one arbiter decision per challenge into a response word.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : puf_response_collector_if.master
//             start/challenge_base from host, arb_done/arb_out from the
//             arbiter (asynchronous), arb_reset/challenge_out to the race
//             stage, busy/bit_index/response/valid/timeout_err to readout.
module puf_response_collector #(
  parameter int unsigned RESP_BITS      = 32,
  parameter int unsigned CHAL_BITS      = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                      clk,
  input logic                      reset_n,
  puf_response_collector_if.master bus
);

  localparam int unsigned IdxW    = $clog2(RESP_BITS);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES);

  localparam logic [IdxW-1:0]    LastIdx    = IdxW'(RESP_BITS - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [TmoW-1:0]    TmoLast    = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StRace, StCapture, StNext, StFinish
  } state_e;

  state_e               state_q, state_d;
  logic                 done_meta_q, done_s_q;
  logic                 out_meta_q, out_s_q;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 timed_out_q, timed_out_d;
  logic [CHAL_BITS-1:0] chal_q, chal_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 arb_reset_q, arb_reset_d;

  // Two-flop synchronisers for the asynchronous arbiter outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      out_meta_q  <= 1'b0;
      out_s_q     <= 1'b0;
    end else begin
      done_meta_q <= bus.arb_done;
      done_s_q    <= done_meta_q;
      out_meta_q  <= bus.arb_out;
      out_s_q     <= out_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    timed_out_d = timed_out_q;
    chal_d      = chal_q;
    idx_d       = idx_q;
    resp_d      = resp_q;
    busy_d      = busy_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          chal_d    = bus.challenge_base;
          resp_d    = '0;
          tmo_err_d = 1'b0;
          idx_d     = '0;
          busy_d    = 1'b1;
          settle_d  = '0;
          state_d   = StClear;
        end
      end
      StClear: begin
        if (settle_q == SettleLast) begin
          tmo_d       = '0;
          timed_out_d = 1'b0;
          state_d     = StRace;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StRace: begin
        // A done_s already high on entry is accepted; CLEAR is long enough
        // to flush the previous race's done through the synchroniser.
        if (done_s_q) begin
          state_d = StCapture;
        end else if (tmo_q == TmoLast) begin
          timed_out_d = 1'b1;
          tmo_err_d   = 1'b1;
          state_d     = StCapture;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCapture: begin
        resp_d[idx_q] = timed_out_q ? 1'b0 : out_s_q;
        state_d       = StNext;
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          state_d = StFinish;
        end else begin
          idx_d    = idx_q + 1'b1;
          chal_d   = chal_q + 1'b1;
          settle_d = '0;
          state_d  = StClear;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered decodes of the next state keep these outputs glitch-free;
    // arb_reset in particular feeds asynchronous resets downstream.
    valid_d     = (state_d == StFinish);
    arb_reset_d = (state_d != StRace);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      tmo_q       <= '0;
      timed_out_q <= 1'b0;
      chal_q      <= '0;
      idx_q       <= '0;
      resp_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      tmo_err_q   <= 1'b0;
      arb_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      timed_out_q <= timed_out_d;
      chal_q      <= chal_d;
      idx_q       <= idx_d;
      resp_q      <= resp_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      tmo_err_q   <= tmo_err_d;
      arb_reset_q <= arb_reset_d;
    end
  end

  assign bus.arb_reset     = arb_reset_q;
  assign bus.challenge_out = chal_q;
  assign bus.busy          = busy_q;
  assign bus.bit_index     = idx_q;
  assign bus.response      = resp_q;
  assign bus.valid         = valid_q;
  assign bus.timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_puf_response_collector.sv
`timescale 1ns / 1ps
module tb_puf_response_collector;

  localparam int unsigned RB     = 4;
  localparam int unsigned CB     = 8;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 32;

  typedef struct {
    logic [CB-1:0] base;
    logic [RB-1:0] resp;
    logic          tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  // Arbiter model: the decision for a challenge is pat[challenge[1:0]];
  // a challenge whose low bits equal hang_sel never completes.
  logic [3:0] pat = 4'b0000;
  int         hang_sel = -1;
  int         race_delay = 20;

  always #5 clk = ~clk;

  puf_response_collector_if #(.RESP_BITS(RB), .CHAL_BITS(CB)) bus ();

  puf_response_collector #(
    .RESP_BITS     (RB),
    .CHAL_BITS     (CB),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arb_reset"}, 64'(bus.arb_reset), 64'(1));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_valid"}, 64'(bus.valid), 64'(0));
    chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'(0));
    chk({tag, "_response"}, 64'(bus.response), 64'(0));
    chk({tag, "_bit_index"}, 64'(bus.bit_index), 64'(0));
    chk({tag, "_challenge_out"}, 64'(bus.challenge_out), 64'(0));
  endtask

  // Arbiter: arb_out wanders at random phase during the race, settles on the
  // real decision a few cycles before done, and both clear under arb_reset.
  initial begin : arb_model
    logic [CB-1:0] c;
    bit            hang;
    bit            aborted;
    bus.arb_done = 1'b0;
    bus.arb_out  = 1'b0;
    forever begin
      wait (bus.arb_reset === 1'b0);
      c       = bus.challenge_out;
      hang    = (int'(c[1:0]) == hang_sel);
      aborted = 1'b0;
      for (int k = 0; k < race_delay && !aborted; k++) begin
        @(posedge clk);
        if (bus.arb_reset !== 1'b0) begin
          aborted = 1'b1;
        end else begin
          #($urandom_range(1, 8));
          if (k < race_delay - 3) bus.arb_out = 1'($urandom_range(0, 1));
          else bus.arb_out = pat[c[1:0]];
        end
      end
      if (!aborted && !hang) bus.arb_done = 1'b1;
      wait (bus.arb_reset === 1'b1);
      #($urandom_range(0, 3));
      bus.arb_done = 1'b0;
      bus.arb_out  = 1'b0;
    end
  end

  // Monitor: race framing, challenge order and response scoreboard.
  int            races = 0;
  int            hi_cnt = 0;
  int            lo_cnt = 0;
  bit            lo_hang = 1'b0;
  logic [CB-1:0] exp_chal;
  always @(negedge clk) begin
    if (!reset_n) begin
      races  = 0;
      hi_cnt = 0;
      lo_cnt = 0;
    end else begin
      if (bus.arb_reset === 1'b0) begin
        if (lo_cnt == 0) begin
          // First race of a sweep follows CLEAR only; later races also
          // follow CAPTURE and NEXT.
          chk("settle_len", 64'(hi_cnt), (races == 0) ? 64'(SETTLE) : 64'(SETTLE + 2));
          chk("bit_index", 64'(bus.bit_index), 64'(races));
          if (sb_q.size() == 0) begin
            fail("race_without_sweep");
          end else begin
            exp_chal = sb_q[0].base + CB'(races);
            chk("challenge_out", 64'(bus.challenge_out), 64'(exp_chal));
          end
          lo_hang = (int'(bus.challenge_out[1:0]) == hang_sel);
          races++;
          hi_cnt = 0;
        end
        lo_cnt++;
      end else begin
        if (lo_cnt != 0 && lo_hang) chk("timeout_race_len", 64'(lo_cnt), 64'(TMO));
        lo_cnt = 0;
        if (bus.busy) hi_cnt++;
      end
      if (bus.valid) begin
        if (sb_q.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("response", 64'(bus.response), 64'(e.resp));
          chk("timeout_err", 64'(bus.timeout_err), 64'(e.tmo));
          chk("races_per_sweep", 64'(races), 64'(RB));
          chk("busy_during_valid", 64'(bus.busy), 64'(1));
        end
        races  = 0;
        hi_cnt = 0;
      end
    end
  end

  task automatic sweep(input logic [CB-1:0] base, input logic [RB-1:0] exp_resp,
                       input logic exp_tmo, input bit noisy);
    exp_t          e;
    bit            seen;
    logic [CB-1:0] last_chal;
    e.base = base;
    e.resp = exp_resp;
    e.tmo  = exp_tmo;
    sb_q.push_back(e);
    seen = 1'b0;
    @(negedge clk);
    bus.start          = 1'b1;
    bus.challenge_base = base;
    @(negedge clk);
    bus.start          = 1'b0;
    bus.challenge_base = 8'h99;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) seen = 1'b1;
      else bus.start = noisy && (k % 37 == 5);
    end
    bus.start = 1'b0;
    if (!seen) fail("valid_never_seen");
    @(negedge clk);
    chk("busy_after_valid", 64'(bus.busy), 64'(0));
    chk("valid_single_pulse", 64'(bus.valid), 64'(0));
    repeat (5) @(negedge clk);
    last_chal = base + CB'(RB - 1);
    chk("response_hold", 64'(bus.response), 64'(exp_resp));
    chk("timeout_err_hold", 64'(bus.timeout_err), 64'(exp_tmo));
    chk("challenge_hold", 64'(bus.challenge_out), 64'(last_chal));
  endtask

  initial begin : stim
    bit hit;
    bus.start          = 1'b0;
    bus.challenge_base = '0;
    #23;
    chk_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic sweep: decisions 1,0,1,1 for 0x10..0x13.
    pat = 4'b1101;
    sweep(8'h10, 4'b1101, 1'b0, 1'b0);

    // Challenge wrap 0xFE,0xFF,0x00,0x01 -> pat[2],pat[3],pat[0],pat[1].
    sweep(8'hFE, 4'b0111, 1'b0, 1'b0);

    // Bit 2 never completes: forced 0 and sticky timeout_err.
    pat      = 4'b1111;
    hang_sel = 2;
    sweep(8'h20, 4'b1011, 1'b1, 1'b0);
    hang_sel = -1;

    // Start pulses while busy must not restart the sweep.
    pat = 4'b0110;
    sweep(8'h40, 4'b0110, 1'b0, 1'b1);

    // Reset in the middle of the race for bit 1.
    pat = 4'b1001;
    begin
      exp_t e;
      e.base = 8'h50;
      e.resp = 4'b1001;
      e.tmo  = 1'b0;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.start          = 1'b1;
    bus.challenge_base = 8'h50;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      hit = (bus.bit_index === 2'd1) && (bus.arb_reset === 1'b0);
    end
    if (!hit) fail("bit1_race_not_reached");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("abort");
    sb_q.delete();
    repeat (4) @(negedge clk);
    chk("abort_no_valid", 64'(bus.valid), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sweep after the abort: 0x08..0x0B -> pat[0..3].
    sweep(8'h08, 4'b1001, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    if (sb_q.size() != 0) fail("scoreboard_not_drained");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
